// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-boundary sequencer and its drain counter.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    PUSH1  = 3'd2,
    PUSH2  = 3'd3,
    VECTOR = 3'd4
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_VEC = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/fetch_ctrl_drain_cnt.sv
// Loadable down-counter that times the drain bubbles; zero marks the last drain cycle.
module fetch_ctrl_drain_cnt
  import fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch / IF-ID boundary control: normal flow, load-use stalls, taken branches
// and the drain -> capture -> int1 -> int2 -> vector interrupt entry sequence.
module fetch_seq_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req,
  input  logic            stall_hazard,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pc_write_en,
  output logic            ifid_enable,
  output logic            ifid_flush,
  output logic [1:0]      pc_src,
  output logic            int1,
  output logic            int2,
  output logic [PC_W-1:0] pc_before_int,
  output logic            busy
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t state, state_next;
  logic   int_pend, int_pend_next;
  logic   cnt_load, cnt_dec, cnt_zero;
  logic   capture;

  fetch_ctrl_drain_cnt u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (DRAIN_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // The return PC is taken on the last drain edge, after any branch has redirected fetch.
  assign capture = (state == DRAIN) && cnt_zero;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      int_pend      <= 1'b0;
      pc_before_int <= '0;
    end else begin
      state    <= state_next;
      int_pend <= int_pend_next;
      if (capture) begin
        pc_before_int <= fetch_pc;
      end
    end
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_enable   = 1'b1;
    ifid_flush    = 1'b0;
    pc_src        = PCSRC_SEQ;
    int1          = 1'b0;
    int2          = 1'b0;
    state_next    = state;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    int_pend_next = int_pend | int_req;

    case (state)
      IDLE: begin
        if (branch_taken) begin
          pc_src     = PCSRC_BR;
          ifid_flush = 1'b1;
        end else if (stall_hazard) begin
          pc_write_en = 1'b0;
          ifid_enable = 1'b0;
        end
        if ((int_pend || int_req) && !stall_hazard) begin
          state_next = DRAIN;
          cnt_load   = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush  = 1'b1;
        pc_write_en = branch_taken;
        if (branch_taken) begin
          pc_src = PCSRC_BR;
        end
        if (cnt_zero) begin
          state_next = PUSH1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PUSH1: begin
        int1        = 1'b1;
        pc_write_en = 1'b0;
        state_next  = PUSH2;
      end
      PUSH2: begin
        int2        = 1'b1;
        pc_write_en = 1'b0;
        state_next  = VECTOR;
      end
      VECTOR: begin
        pc_src        = PCSRC_VEC;
        ifid_flush    = 1'b1;
        state_next    = IDLE;
        int_pend_next = int_req;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios plus randomized
// traffic compared against a sequence-position reference model.
module tb_fetch_seq_ctrl;

  localparam int PC_W = 32;
  localparam int D    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            int_req, stall_hazard, branch_taken;
  logic [PC_W-1:0] fetch_pc;
  logic            pc_write_en, ifid_enable, ifid_flush, int1, int2, busy;
  logic [1:0]      pc_src;
  logic [PC_W-1:0] pc_before_int;
  logic [7:0]      obs;

  int tests  = 0;
  int failed = 0;

  // Reference model: -1 = idle, otherwise cycles since leaving idle.
  int              m_pos;
  bit              m_pend;
  logic [PC_W-1:0] m_ret;

  always #5 clk = ~clk;

  fetch_seq_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .int_req       (int_req),
    .stall_hazard  (stall_hazard),
    .branch_taken  (branch_taken),
    .fetch_pc      (fetch_pc),
    .pc_write_en   (pc_write_en),
    .ifid_enable   (ifid_enable),
    .ifid_flush    (ifid_flush),
    .pc_src        (pc_src),
    .int1          (int1),
    .int2          (int2),
    .pc_before_int (pc_before_int),
    .busy          (busy)
  );

  assign obs = {pc_write_en, ifid_enable, ifid_flush, pc_src, int1, int2, busy};

  function automatic logic [7:0] model_exp();
    logic we, en, fl, i1, i2, bz;
    logic [1:0] src;
    we = 1'b1; en = 1'b1; fl = 1'b0; src = 2'b00; i1 = 1'b0; i2 = 1'b0;
    bz = (m_pos >= 0);
    if (m_pos < 0) begin
      if (branch_taken) begin
        src = 2'b01; fl = 1'b1;
      end else if (stall_hazard) begin
        we = 1'b0; en = 1'b0;
      end
    end else if (m_pos < D) begin
      fl = 1'b1; we = branch_taken; src = branch_taken ? 2'b01 : 2'b00;
    end else if (m_pos == D) begin
      we = 1'b0; i1 = 1'b1;
    end else if (m_pos == D + 1) begin
      we = 1'b0; i2 = 1'b1;
    end else begin
      src = 2'b10; fl = 1'b1;
    end
    return {we, en, fl, src, i1, i2, bz};
  endfunction

  task automatic model_reset();
    m_pos  = -1;
    m_pend = 1'b0;
    m_ret  = '0;
  endtask

  task automatic drive(input logic ir, input logic st, input logic br, input logic [PC_W-1:0] pc);
    int_req      = ir;
    stall_hazard = st;
    branch_taken = br;
    fetch_pc     = pc;
    #1;
  endtask

  task automatic advance();
    bit leaving_vec;
    @(posedge clk);
    leaving_vec = (m_pos == D + 2);
    if (m_pos < 0) begin
      if ((m_pend || int_req) && !stall_hazard) m_pos = 0;
    end else if (leaving_vec) begin
      m_pos = -1;
    end else begin
      if (m_pos == D - 1) m_ret = fetch_pc;
      m_pos++;
    end
    m_pend = int_req || (m_pend && !leaving_vec);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    tests++;
    if (obs !== 8'b1100_0000) begin
      failed++;
      $display("[TB] FAIL reset_outputs got %b want %b", obs, 8'b1100_0000);
    end
    tests++;
    if (pc_before_int !== '0) begin
      failed++;
      $display("[TB] FAIL reset_pc got %h want 0", pc_before_int);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall_vs_branch();
    logic [7:0] want [4];
    logic [2:0] pat  [4];
    want[0] = 8'b1110_1000; pat[0] = 3'b011;
    want[1] = 8'b0000_0000; pat[1] = 3'b010;
    want[2] = 8'b1110_1000; pat[2] = 3'b001;
    want[3] = 8'b1100_0000; pat[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      drive(pat[i][2], pat[i][1], pat[i][0], 32'h0000_0200 + i);
      tests++;
      if (obs !== want[i]) begin
        failed++;
        $display("[TB] FAIL stall_branch_%0d got %b want %b", i, obs, want[i]);
      end
      advance();
    end
  endtask

  task automatic test_basic_interrupt();
    logic [7:0] seq [D + 4];
    for (int i = 0; i < D; i++) seq[i] = 8'b0110_0001;
    seq[D]     = 8'b0100_0101;
    seq[D + 1] = 8'b0100_0011;
    seq[D + 2] = 8'b1111_0001;
    seq[D + 3] = 8'b1100_0000;
    drive(1'b1, 1'b0, 1'b0, 32'h40);
    tests++;
    if (obs !== 8'b1100_0000) begin
      failed++;
      $display("[TB] FAIL basic_req_cycle got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    for (int c = 0; c < D + 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h40);
      tests++;
      if (obs !== seq[c]) begin
        failed++;
        $display("[TB] FAIL basic_seq_%0d got %b want %b", c, obs, seq[c]);
      end
      advance();
    end
    tests++;
    if (pc_before_int !== 32'h40) begin
      failed++;
      $display("[TB] FAIL basic_ret_pc got %h want %h", pc_before_int, 32'h40);
    end
  endtask

  task automatic test_branch_during_drain();
    drive(1'b1, 1'b0, 1'b0, 32'h80);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h80);
    tests++;
    if (obs !== 8'b1110_1001) begin
      failed++;
      $display("[TB] FAIL drain_branch got %b want %b", obs, 8'b1110_1001);
    end
    advance();
    for (int c = 1; c < D + 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h100);
      tests++;
      if (obs !== model_exp()) begin
        failed++;
        $display("[TB] FAIL drain_branch_seq_%0d got %b want %b", c, obs, model_exp());
      end
      advance();
    end
    tests++;
    if (pc_before_int !== 32'h100) begin
      failed++;
      $display("[TB] FAIL drain_branch_ret_pc got %h want %h", pc_before_int, 32'h100);
    end
  endtask

  task automatic test_request_timing();
    drive(1'b1, 1'b1, 1'b0, 32'h300);
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h300);
      tests++;
      if (obs !== 8'b0000_0000) begin
        failed++;
        $display("[TB] FAIL stalled_req_%0d got %b want %b", c, obs, 8'b0000_0000);
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h300);
    advance();
    // Hold the request through the whole sequence to force an immediate rerun.
    for (int c = 0; c < D + 3; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h300);
      tests++;
      if (obs !== model_exp() || busy !== 1'b1) begin
        failed++;
        $display("[TB] FAIL held_req_seq_%0d got %b want %b", c, obs, model_exp());
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h300);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL gap_idle busy got %b want 0", busy);
    end
    advance();
    for (int c = 0; c < D + 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h300);
      tests++;
      if (obs !== model_exp() || busy !== 1'b1) begin
        failed++;
        $display("[TB] FAIL rerun_seq_%0d got %b want %b", c, obs, model_exp());
      end
      advance();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h300);
      tests++;
      if (busy !== 1'b0) begin
        failed++;
        $display("[TB] FAIL no_third_run_%0d busy got %b want 0", c, busy);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    drive(1'b1, 1'b0, 1'b0, 32'h1234);
    advance();
    budget = 0;
    while (m_pos != D && budget < 10) begin
      drive(1'b0, 1'b0, 1'b0, 32'h1234);
      advance();
      budget++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h1234);
    tests++;
    if (int1 !== 1'b1 || pc_before_int !== 32'h1234) begin
      failed++;
      $display("[TB] FAIL mid_reach_push1 int1 %b pc %h want 1 %h", int1, pc_before_int, 32'h1234);
    end
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs !== 8'b1100_0000) begin
      failed++;
      $display("[TB] FAIL mid_reset_outputs got %b want %b", obs, 8'b1100_0000);
    end
    tests++;
    if (pc_before_int !== '0) begin
      failed++;
      $display("[TB] FAIL mid_reset_pc got %h want 0", pc_before_int);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h1234);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL mid_reset_pend_cleared busy got %b want 0", busy);
    end
    advance();
  endtask

  task automatic test_random();
    logic ir, st, br;
    for (int c = 0; c < 400; c++) begin
      ir = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 3) == 0);
      drive(ir, st, br, $urandom);
      tests++;
      if (obs !== model_exp()) begin
        failed++;
        $display("[TB] FAIL random_out_%0d got %b want %b", c, obs, model_exp());
      end
      tests++;
      if (int1 === 1'b1 && int2 === 1'b1) begin
        failed++;
        $display("[TB] FAIL random_markers_%0d int1 %b int2 %b want not both", c, int1, int2);
      end
      advance();
      tests++;
      if (pc_before_int !== m_ret) begin
        failed++;
        $display("[TB] FAIL random_ret_pc_%0d got %h want %h", c, pc_before_int, m_ret);
      end
    end
  endtask

  initial begin
    int_req      = 1'b0;
    stall_hazard = 1'b0;
    branch_taken = 1'b0;
    fetch_pc     = '0;
    test_reset();
    test_stall_vs_branch();
    test_basic_interrupt();
    test_branch_during_drain();
    test_request_timing();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
